// File: rtl/sw_debounce_pkg.sv
// Shared helpers and board defaults for the switch debouncer.
// Optional edge outputs are enabled with SW_DEBOUNCE_EDGE_OUT_EN.
package sw_debounce_pkg;

    localparam int DEF_WIDTH        = 18;
    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_TICK_HZ      = 1000;
    localparam int DEF_STABLE_TICKS = 10;

    // Clocks per sample tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter width able to hold 0..stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, output bit.
// Edge pulse outputs exist only when SW_DEBOUNCE_EDGE_OUT_EN is defined.
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic flip
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int            CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        level_next = level;
        cnt_next   = cnt;
        if (s2 == level) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt == LAST) begin
                level_next = s2;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign flip = level_next ^ level;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= RESET_VAL;
            s2    <= RESET_VAL;
            cnt   <= '0;
            level <= RESET_VAL;
        end else begin
            s1    <= raw;
            s2    <= s1;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_OUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= level_next & ~level;
            fall <= ~level_next & level;
        end
    end
`endif

endmodule

// File: rtl/sw_debounce.sv
// Switch-bank synchronizer/debouncer feeding the switch PIO in_port.
// Define SW_DEBOUNCE_EDGE_OUT_EN to add per-bit rise_pulse/fall_pulse outputs.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int               WIDTH        = DEF_WIDTH,
    parameter int               CLK_HZ       = DEF_CLK_HZ,
    parameter int               TICK_HZ      = DEF_TICK_HZ,
    parameter int               STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed,
    output logic             tick
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`endif
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("sw_debounce: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("sw_debounce: STABLE_TICKS must be at least 1");
    end

    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] flip;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pre == PRE_LAST);
            pre  <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sw_debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VAL   (RESET_VAL[i])
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .raw  (sw_in[i]),
            .level(sw_out[i]),
            .flip (flip[i])
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
            ,
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
`endif
        );
    end

    // One pulse per cycle in which any channel accepts a new level.
    always_ff @(posedge clk) begin
        if (reset) changed <= 1'b0;
        else       changed <= |flip;
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce at DIV=10, STABLE_TICKS=3, WIDTH=18.
// Edge-pulse checks are active when SW_DEBOUNCE_EDGE_OUT_EN is defined.
module tb_sw_debounce;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic         changed;
    logic         tick;
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
`endif

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .WIDTH       (W),
        .CLK_HZ      (100),
        .TICK_HZ     (10),
        .STABLE_TICKS(3),
        .RESET_VAL   ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .sw_out    (sw_out),
        .changed   (changed),
        .tick      (tick)
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
        ,
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until changed is seen; n = cycles taken.
    task automatic wait_changed(input string tag, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!changed && n < limit);
        check(tag, 32'(changed), 32'd1);
    endtask

    task automatic wait_tick(input string tag, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < limit);
        check(tag, 32'(tick), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;

        // 1. Reset with all inputs high.
        reset = 1'b1;
        sw_in = '1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("rst_out", 32'(sw_out), 32'h0);
            check("rst_changed", 32'(changed), 32'h0);
            check("rst_tick", 32'(tick), 32'h0);
        end
        sw_in = '0;
        reset = 1'b0;
        wait_tick("first_tick_seen", 50, n);
        check("first_tick_delay", 32'(n), 32'd10);
        wait_tick("tick_period_seen", 50, n);
        check("tick_period", 32'(n), 32'd10);

        // 2. Clean step on bit 0.
        sw_in[0] = 1'b1;
        wait_changed("step_seen", 60, n);
        check("step_latency_range", 32'(n >= 23 && n <= 32), 32'd1);
        check("step_out", 32'(sw_out), 32'h00001);
        step();
        check("step_changed_1cyc", 32'(changed), 32'd0);
        check("step_hold", 32'(sw_out), 32'h00001);

        // 3. Bounce on bit 5: 7-cycle toggles never qualify.
        pulses = 0;
        for (int c = 0; c < 180; c++) begin
            if (c < 140 && c % 7 == 0) sw_in[5] = ~sw_in[5];
            step();
            if (changed) pulses++;
        end
        check("bounce_pulses", 32'(pulses), 32'd0);
        check("bounce_out", 32'(sw_out), 32'h00001);

        // 4. Simultaneous flip of bits 17:16, then bit 16 alone.
        sw_in[17:16] = 2'b11;
        wait_changed("simul_seen", 60, n);
        check("simul_out", 32'(sw_out), 32'h30001);
        step();
        check("simul_one_pulse", 32'(changed), 32'd0);
        sw_in[16] = 1'b0;
        wait_changed("single_seen", 60, n);
        check("single_out", 32'(sw_out), 32'h20001);
        step();
        check("single_one_pulse", 32'(changed), 32'd0);

        // 5. Reset one cycle after the 2nd qualifying tick of bit 3.
        wait_tick("align_tick", 50, n);
        sw_in[3] = 1'b1;
        wait_tick("mid_tick1", 50, n);
        wait_tick("mid_tick2", 50, n);
        step();
        check("mid_pre_reset", 32'(sw_out), 32'h20001);
        reset = 1'b1;
        step();
        check("mid_reset_out", 32'(sw_out), 32'h0);
        check("mid_reset_changed", 32'(changed), 32'd0);
        reset = 1'b0;
        wait_changed("rearm_seen", 60, n);
        check("rearm_latency", 32'(n), 32'd31);
        check("rearm_out", 32'(sw_out), 32'h20009);

        // 6. Rise then fall of bit 9 with edge pulses.
        sw_in[9] = 1'b1;
        wait_changed("rise_seen", 60, n);
        check("rise_out", 32'(sw_out), 32'h20209);
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
        check("rise_pulse", 32'(rise_pulse), 32'h00200);
        check("rise_no_fall", 32'(fall_pulse), 32'h0);
`endif
        step();
        check("rise_changed_1cyc", 32'(changed), 32'd0);
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
        check("rise_pulse_1cyc", 32'(rise_pulse), 32'h0);
`endif
        sw_in[9] = 1'b0;
        wait_changed("fall_seen", 60, n);
        check("fall_out", 32'(sw_out), 32'h20009);
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
        check("fall_pulse", 32'(fall_pulse), 32'h00200);
        check("fall_no_rise", 32'(rise_pulse), 32'h0);
`endif
        step();
        check("fall_changed_1cyc", 32'(changed), 32'd0);
`ifdef SW_DEBOUNCE_EDGE_OUT_EN
        check("fall_pulse_1cyc", 32'(fall_pulse), 32'h0);
`endif

        // Quiet: input equals output, only tick keeps running.
        pulses = 0;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (changed) pulses++;
            if (tick) n++;
        end
        check("quiet_pulses", 32'(pulses), 32'd0);
        check("quiet_ticks", 32'(n), 32'd6);
        check("quiet_out", 32'(sw_out), 32'h20009);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
